// File: rtl/ped_request_ctrl.sv
// Pedestrian button front end: sync, debounce, request pulse, timed WALK.
// Optional re-pulse of an unanswered request: define PED_RETRY_EN.
module ped_request_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WALK_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             button,
    input  logic                             ped_light,
    output logic                             ped_toggle,
    output logic                             req_pending,
    output logic                             walk,
    output logic [$clog2(WALK_CYCLES+1)-1:0] walk_count,
    output logic [7:0]                       served_count,
    output logic                             fault
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int WW = $clog2(WALK_CYCLES + 1);

    if (DEBOUNCE_CYCLES < 1 || WALK_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : gBadCfg
        $error("ped_request_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WALK,
        RELEASE
    } state_t;

    state_t        state;
    logic          sync1;
    logic          btnS;
    logic [DW-1:0] debCount;
    logic          debLevel;
    logic          deb;
    logic          pressEvt;

    // pressEvt marks the edge on which deb rises, so the pulse lines up with it
    assign deb      = debLevel & btnS;
    assign pressEvt = btnS && (debCount == DW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1    <= 1'b0;
            btnS     <= 1'b0;
            debCount <= '0;
            debLevel <= 1'b0;
        end else begin
            sync1 <= button;
            btnS  <= sync1;
            if (!btnS) begin
                debCount <= '0;
                debLevel <= 1'b0;
            end else if (debCount != DW'(DEBOUNCE_CYCLES)) begin
                debCount <= debCount + 1'b1;
                if (pressEvt) debLevel <= 1'b1;
            end
        end
    end

`ifdef PED_RETRY_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] retryTimer;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            ped_toggle   <= 1'b0;
            req_pending  <= 1'b0;
            walk         <= 1'b0;
            walk_count   <= '0;
            served_count <= '0;
            fault        <= 1'b0;
`ifdef PED_RETRY_EN
            retryTimer   <= '0;
`endif
        end else begin
            ped_toggle <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ped_light) fault <= 1'b1;
                    if (pressEvt) begin
                        state       <= REQ;
                        ped_toggle  <= 1'b1;
                        req_pending <= 1'b1;
`ifdef PED_RETRY_EN
                        retryTimer  <= '0;
`endif
                    end
                end
                REQ: begin
                    if (ped_light) begin
                        state        <= WALK;
                        req_pending  <= 1'b0;
                        walk         <= 1'b1;
                        walk_count   <= WW'(WALK_CYCLES);
                        served_count <= served_count + 8'd1;
                    end
`ifdef PED_RETRY_EN
                    else if (retryTimer == TW'(TIMEOUT_CYCLES - 1)) begin
                        ped_toggle <= 1'b1;
                        retryTimer <= '0;
                    end else begin
                        retryTimer <= retryTimer + 1'b1;
                    end
`endif
                end
                WALK: begin
                    walk_count <= walk_count - 1'b1;
                    if (walk_count == WW'(1)) begin
                        walk  <= 1'b0;
                        state <= deb ? RELEASE : IDLE;
                    end
                end
                RELEASE: begin
                    // held button must drop before a new request can start
                    if (ped_light) fault <= 1'b1;
                    if (!deb) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ped_request_ctrl.md
# ped_request_ctrl

Pedestrian push-button front end for the intersection traffic light controller. Synchronizes and debounces the raw crossing button, issues a single-cycle `ped_toggle` request pulse to the controller, and waits for the controller's `ped_light` serve indication. It then stretches that indication into a timed WALK phase with a countdown. It sits between the button/lamp I/O and the controller's `pedToggle`/`pedLight` pins, on the same clock.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized-high samples needed to accept a press (≥1).
- `WALK_CYCLES`, default 8: cycles the `walk` output is held per serve (≥1).
- `TIMEOUT_CYCLES`, default 16: REQ cycles before a retry pulse; used only with `PED_RETRY_EN` (≥2).
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `button`  in  1  raw asynchronous push-button level, 1 = pressed.
- `ped_light`  in  1  serve indication from the controller, synchronous to `clk`.
- `ped_toggle`  out  1  request pulse to the controller, registered, exactly one cycle wide.
- `req_pending`  out  1  WAIT lamp; 1 while a request is outstanding.
- `walk`  out  1  WALK lamp.
- `walk_count`  out  $clog2(WALK_CYCLES+1)  remaining WALK cycles; 0 outside WALK.
- `served_count`  out  8  number of requests served; wraps 255→0.
- `fault`  out  1  sticky: `ped_light` seen while no request was outstanding.

## Operation
- Input path: two-flop synchronizer `button`→`btn_s`. The debounce counter increments while `btn_s`=1 and clears when `btn_s`=0. Debounced level `deb` is set when the counter reaches `DEBOUNCE_CYCLES` and clears in the same cycle `btn_s` drops. `press` = rising edge of `deb`.
- FSM states: IDLE, REQ, WALK, RELEASE.
- IDLE: on `press` → REQ and pulse `ped_toggle`.
- REQ: `req_pending`=1. On `ped_light`=1 → WALK, load `walk_count`=`WALK_CYCLES`, increment `served_count`. Presses in REQ are ignored; there is no second pulse.
- WALK: `walk`=1; `walk_count` decrements each cycle. On the cycle `walk_count`=1: → IDLE if `deb`=0, else → RELEASE. `ped_light` in WALK is ignored and does not set `fault`.
- RELEASE: all lamps off. Stay until `deb`=0, then → IDLE. This blocks auto-repeat from a held button.
- `fault`: set on any cycle `ped_light`=1 in IDLE or RELEASE. Cleared only by reset.

## Timing
- Reset (async assert): state IDLE; synchronizer, debounce counter, and timers cleared. All outputs 0: `ped_toggle`, `req_pending`, `walk`, `walk_count`, `served_count`, `fault`.
- Reset mid-REQ or mid-WALK drops the request with no pulse. A button still held after release of `reset_n` is a fresh press once it has debounced.
- Press latency: `button` is first sampled high at edge k and held. `deb`=1 after edge k+1+`DEBOUNCE_CYCLES`. `ped_toggle`=1 for exactly the following cycle, with `req_pending`=1 from the same cycle.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronized samples produces no pulse.
- Serve: `ped_light` sampled 1 at edge n (state REQ). From edge n onward: `walk`=1, `req_pending`=0, `walk_count`=`WALK_CYCLES`, `served_count`+1. `walk` stays high for exactly `WALK_CYCLES` cycles.
- `ped_light` may be held for any number of cycles; only its first REQ cycle counts.
- `ped_light` in the cycle the `ped_toggle` pulse is high is accepted.

## Configuration
- `PED_RETRY_EN` defined: in REQ, a timer counts cycles since the last `ped_toggle` pulse. When it reaches `TIMEOUT_CYCLES`, `ped_toggle` re-pulses for one cycle and the timer restarts. If `ped_light`=1 on the timeout cycle, the serve wins and no pulse is issued.
- `PED_RETRY_EN` undefined: no timer. REQ waits indefinitely after the single pulse.

## Test plan
- Defaults. Hold `button` high from edge 10 → one `ped_toggle` pulse in the cycle after edge 15, `req_pending`=1. Drive `ped_light` for 1 cycle at edge 30 → `walk`=1 for 8 cycles, `walk_count` 8..1, `served_count`=1.
- Button high for 3 cycles, then low → no `ped_toggle`, state stays IDLE, all outputs 0.
- Keep `button` held through and after WALK → state RELEASE, no second pulse. Release the button, then press again → a new pulse occurs.
- `ped_light`=1 while IDLE → `fault`=1 and stays 1 after further serves. Only `reset_n`=0 clears it.
- Assert `reset_n`=0 mid-WALK (`walk_count`=5) → all outputs 0 immediately, asynchronously.
- `PED_RETRY_EN` defined, `TIMEOUT_CYCLES`=16, no `ped_light` → `ped_toggle` pulses 16 cycles apart. Without the macro → only one pulse.
